// File: rtl/perceptron_comm_ctrl_if.sv
// UART-side byte interface of the perceptron packet controller.
// master = the UART core, slave = the protocol controller.
interface perceptron_comm_ctrl_if;
  logic       uart_new_value;
  logic [7:0] uart_recvd_data;
  logic       uart_error;
  logic       uart_tx_busy;
  logic       uart_clear;
  logic       uart_start_transmit;
  logic [7:0] uart_data_to_send;

  modport master (
    output uart_new_value, uart_recvd_data, uart_error, uart_tx_busy,
    input  uart_clear, uart_start_transmit, uart_data_to_send
  );

  modport slave (
    input  uart_new_value, uart_recvd_data, uart_error, uart_tx_busy,
    output uart_clear, uart_start_transmit, uart_data_to_send
  );
endinterface

// File: rtl/perceptron_comm_ctrl.sv
// Packet responder between the byte UART and the perceptron: decodes opcodes,
// latches weight/input pairs atomically and serialises response packets.
module perceptron_comm_ctrl #(
  parameter int unsigned fp_integer_width = 4,
  parameter int unsigned fp_fract_width   = 4,
  parameter int unsigned timeout_cycles   = 1200000
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  perceptron_comm_ctrl_if.slave                       uart,
  output logic [fp_integer_width+fp_fract_width-1:0] weight1,
  output logic [fp_integer_width+fp_fract_width-1:0] weight2,
  output logic [fp_integer_width+fp_fract_width-1:0] input1,
  output logic [fp_integer_width+fp_fract_width-1:0] input2,
  output logic                                        weights_wr,
  output logic                                        inputs_wr,
  input  logic                                        result
);
  localparam int W  = fp_integer_width + fp_fract_width;
  localparam int TW = $clog2(timeout_cycles + 1);

  localparam logic [7:0] OP_READ      = 8'd5;
  localparam logic [7:0] OP_WR_WEIGHT = 8'd50;
  localparam logic [7:0] OP_WR_INPUT  = 8'd51;
  localparam logic [7:0] RSP_READ     = 8'd100;
  localparam logic [7:0] RSP_ACK      = 8'd101;
  localparam logic [7:0] RSP_NAK      = 8'd102;

  typedef enum logic [2:0] {
    IDLE, RX_PAYLOAD, COMMIT, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic          new_prev_q;
  logic          clear_q, clear_d;
  logic          start_q, start_d;
  logic [7:0]    data_q, data_d;
  logic [W-1:0]  w1_q, w1_d, w2_q, w2_d, i1_q, i1_d, i2_q, i2_d;
  logic          wwr_q, wwr_d, iwr_q, iwr_d;
  logic          sel_inputs_q, sel_inputs_d;
  logic [1:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    shadow_q [4];
  logic [7:0]    shadow_d [4];
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_buf_q [7];
  logic [7:0]    tx_buf_d [7];
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [2:0]    tx_len_q, tx_len_d;

  logic          capture;
  logic [15:0]   w1_ext, w2_ext;
  logic [W-1:0]  rx_word_a, rx_word_b;

  assign capture   = uart.uart_new_value & ~new_prev_q;
  assign w1_ext    = 16'(w1_q);
  assign w2_ext    = 16'(w2_q);
  assign rx_word_a = W'({shadow_q[0], shadow_q[1]});
  assign rx_word_b = W'({shadow_q[2], shadow_q[3]});

  always_comb begin
    state_d      = state_q;
    clear_d      = capture;
    start_d      = start_q;
    data_d       = data_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    i1_d         = i1_q;
    i2_d         = i2_q;
    wwr_d        = 1'b0;
    iwr_d        = 1'b0;
    sel_inputs_d = sel_inputs_q;
    rx_idx_d     = rx_idx_q;
    shadow_d     = shadow_q;
    timer_d      = timer_q;
    tx_buf_d     = tx_buf_q;
    tx_idx_d     = tx_idx_q;
    tx_len_d     = tx_len_q;

    unique case (state_q)
      IDLE: begin
        // A byte flagged with a framing error is dropped without reply.
        if (capture && !uart.uart_error) begin
          tx_idx_d = 3'd0;
          if (uart.uart_recvd_data == OP_READ) begin
            tx_buf_d[0] = RSP_READ;
            tx_buf_d[1] = w1_ext[15:8];
            tx_buf_d[2] = w1_ext[7:0];
            tx_buf_d[3] = w2_ext[15:8];
            tx_buf_d[4] = w2_ext[7:0];
            tx_buf_d[5] = 8'h00;
            tx_buf_d[6] = {7'b0, result};
            tx_len_d    = 3'd7;
            state_d     = TX_LOAD;
          end else if (uart.uart_recvd_data == OP_WR_WEIGHT ||
                       uart.uart_recvd_data == OP_WR_INPUT) begin
            sel_inputs_d = (uart.uart_recvd_data == OP_WR_INPUT);
            rx_idx_d     = 2'd0;
            timer_d      = '0;
            state_d      = RX_PAYLOAD;
          end else begin
            tx_buf_d[0] = RSP_NAK;
            tx_len_d    = 3'd1;
            state_d     = TX_LOAD;
          end
        end
      end
      RX_PAYLOAD: begin
        if (uart.uart_error || (!capture && timer_q == TW'(timeout_cycles))) begin
          tx_buf_d[0] = RSP_NAK;
          tx_len_d    = 3'd1;
          tx_idx_d    = 3'd0;
          timer_d     = '0;
          state_d     = TX_LOAD;
        end else if (capture) begin
          shadow_d[rx_idx_q] = uart.uart_recvd_data;
          timer_d            = '0;
          rx_idx_d           = rx_idx_q + 2'd1;
          if (rx_idx_q == 2'd3) state_d = COMMIT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      COMMIT: begin
        // Both halves of the pair land in the same cycle as the strobe.
        if (sel_inputs_q) begin
          i1_d  = rx_word_a;
          i2_d  = rx_word_b;
          iwr_d = 1'b1;
        end else begin
          w1_d  = rx_word_a;
          w2_d  = rx_word_b;
          wwr_d = 1'b1;
        end
        tx_buf_d[0] = RSP_ACK;
        tx_len_d    = 3'd1;
        tx_idx_d    = 3'd0;
        state_d     = TX_LOAD;
      end
      TX_LOAD: begin
        data_d  = tx_buf_q[tx_idx_q];
        start_d = 1'b1;
        state_d = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (uart.uart_tx_busy) begin
          start_d = 1'b0;
          state_d = TX_WAIT_IDLE;
        end
      end
      TX_WAIT_IDLE: begin
        if (!uart.uart_tx_busy) begin
          if (tx_idx_q == tx_len_q - 3'd1) begin
            state_d = IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            state_d  = TX_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      new_prev_q   <= 1'b0;
      clear_q      <= 1'b0;
      start_q      <= 1'b0;
      data_q       <= 8'h00;
      w1_q         <= '0;
      w2_q         <= '0;
      i1_q         <= '0;
      i2_q         <= '0;
      wwr_q        <= 1'b0;
      iwr_q        <= 1'b0;
      sel_inputs_q <= 1'b0;
      rx_idx_q     <= 2'd0;
      timer_q      <= '0;
      tx_idx_q     <= 3'd0;
      tx_len_q     <= 3'd0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 8'h00;
      for (int i = 0; i < 7; i++) tx_buf_q[i] <= 8'h00;
    end else begin
      state_q      <= state_d;
      new_prev_q   <= uart.uart_new_value;
      clear_q      <= clear_d;
      start_q      <= start_d;
      data_q       <= data_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      i1_q         <= i1_d;
      i2_q         <= i2_d;
      wwr_q        <= wwr_d;
      iwr_q        <= iwr_d;
      sel_inputs_q <= sel_inputs_d;
      rx_idx_q     <= rx_idx_d;
      timer_q      <= timer_d;
      tx_idx_q     <= tx_idx_d;
      tx_len_q     <= tx_len_d;
      shadow_q     <= shadow_d;
      tx_buf_q     <= tx_buf_d;
    end
  end

  assign uart.uart_clear          = clear_q;
  assign uart.uart_start_transmit = start_q;
  assign uart.uart_data_to_send   = data_q;
  assign weight1    = w1_q;
  assign weight2    = w2_q;
  assign input1     = i1_q;
  assign input2     = i2_q;
  assign weights_wr = wwr_q;
  assign inputs_wr  = iwr_q;
endmodule
